// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO reader-side adapter.
// Holds the read latency, holding-buffer depth and pointer helpers.
package fifo_pkg;

   localparam int READ_LATENCY = 1;
   localparam int SKID_DEPTH   = 3;

   typedef logic [1:0] skid_ptr_t;

   // Advance a holding-buffer index, wrapping at the last entry.
   function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
      return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/fifo_read_skid_buf.sv
// 3-entry circular holding buffer that absorbs the FIFO read latency.
// Ports: clk_i/rst_i, push_i+data_i (landing word), pop_i (downstream
// accept), occ_o (occupancy), valid_o/data_o (head word, 0 when empty).
module fifo_read_skid_buf
   import fifo_pkg::*;
#(
   parameter int SIZE_DATA = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [SIZE_DATA-1:0] data_i,
   input  logic                 pop_i,
   output logic [1:0]           occ_o,
   output logic                 valid_o,
   output logic [SIZE_DATA-1:0] data_o
);

   logic [SIZE_DATA-1:0] mem_q [SKID_DEPTH];
   skid_ptr_t            head_q, head_d;
   skid_ptr_t            tail_q, tail_d;
   logic [1:0]           occ_q, occ_d;
   logic                 pop;

   assign pop = pop_i && (occ_q != 2'd0);

   always_comb begin
      head_d = pop ? ptr_inc(head_q) : head_q;
      tail_d = push_i ? ptr_inc(tail_q) : tail_q;
      occ_d  = occ_q;
      case ({push_i, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Storage needs no reset: occupancy gates what is visible.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[tail_q] <= data_i;
      end
   end

   assign occ_o   = occ_q;
   assign valid_o = (occ_q != 2'd0);
   assign data_o  = valid_o ? mem_q[head_q] : '0;

endmodule

// File: rtl/fifo_read_adapter.sv
// Reader end of a synchronous FIFO: drains it into a valid/ready stream.
// Ports: i_clk/i_rst, i_enable, FIFO read side (o_fifo_rd_en, i_fifo_empty,
// i_fifo_data), stream (o_valid, o_data, i_ready), o_word_count, o_busy.
module fifo_read_adapter
   import fifo_pkg::*;
#(
   parameter int SIZE_DATA   = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic                   i_fifo_empty,
   input  logic [SIZE_DATA-1:0]   i_fifo_data,
   output logic                   o_fifo_rd_en,
   output logic                   o_valid,
   output logic [SIZE_DATA-1:0]   o_data,
   input  logic                   i_ready,
   output logic [COUNT_WIDTH-1:0] o_word_count,
   output logic                   o_busy
);

   logic [READ_LATENCY-1:0] inflight_q;
   logic [COUNT_WIDTH-1:0]  count_q, count_d;
   logic [1:0]              occ;
   logic [2:0]              used;
   logic                    pop;

   // Credits count both buffered words and the word still in flight,
   // so a read is only issued when its landing slot is guaranteed.
   assign used = {1'b0, occ} + {2'b00, inflight_q[0]};

   assign o_fifo_rd_en = !i_rst && i_enable && !i_fifo_empty &&
                         (used < 3'(SKID_DEPTH));

   assign pop     = o_valid && i_ready;
   assign count_d = pop ? count_q + COUNT_WIDTH'(1) : count_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         inflight_q <= '0;
         count_q    <= '0;
      end else begin
         inflight_q <= o_fifo_rd_en;
         count_q    <= count_d;
      end
   end

   fifo_read_skid_buf #(
      .SIZE_DATA(SIZE_DATA)
   ) u_skid (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .push_i (inflight_q[0]),
      .data_i (i_fifo_data),
      .pop_i  (pop),
      .occ_o  (occ),
      .valid_o(o_valid),
      .data_o (o_data)
   );

   assign o_word_count = count_q;
   assign o_busy       = (occ != 2'd0) || inflight_q[0];

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Scoreboard bench for fifo_read_adapter with a behavioural FIFO model.
// Words are queued as expected when written into the model FIFO.
module tb_fifo_read_adapter;

   localparam int SD = 8;
   localparam int CW = 4;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_enable = 1'b0;
   logic          i_fifo_empty;
   logic [SD-1:0] i_fifo_data = '0;
   logic          o_fifo_rd_en;
   logic          o_valid;
   logic [SD-1:0] o_data;
   logic          i_ready = 1'b0;
   logic [CW-1:0] o_word_count;
   logic          o_busy;

   int n_tests = 0;
   int n_fail  = 0;

   int            pushed = 0;
   int            popped = 0;
   logic [7:0]    fmem [256];
   logic [7:0]    exp_q [$];
   int            outst = 0;

   fifo_read_adapter #(
      .SIZE_DATA(SD),
      .COUNT_WIDTH(CW)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_enable    (i_enable),
      .i_fifo_empty(i_fifo_empty),
      .i_fifo_data (i_fifo_data),
      .o_fifo_rd_en(o_fifo_rd_en),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .i_ready     (i_ready),
      .o_word_count(o_word_count),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Model FIFO: registered read data, one cycle after the strobe.
   assign i_fifo_empty = (pushed == popped);

   always @(posedge i_clk) begin
      if (o_fifo_rd_en) begin
         i_fifo_data <= fmem[popped[7:0]];
         popped      <= popped + 1;
      end
   end

   // Words read but not yet handed downstream must never exceed 3.
   always @(posedge i_clk) begin
      if (i_rst) outst <= 0;
      else outst <= outst + int'(o_fifo_rd_en) - int'(o_valid && i_ready);
   end

   always @(negedge i_clk) begin
      assert (outst <= 3)
         else $error("FAIL occ_bound: outstanding %0d, limit 3", outst);
   end

   task automatic push_word(input logic [7:0] w);
      fmem[pushed[7:0]] = w;
      pushed++;
      exp_q.push_back(w);
   endtask

   task automatic do_reset();
      i_rst    = 1'b1;
      i_enable = 1'b0;
      i_ready  = 1'b0;
      pushed   = popped;
      exp_q.delete();
      @(posedge i_clk); #1;
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst    = 1'b1;
      i_enable = 1'b1;
      i_ready  = 1'b1;
      fmem[pushed[7:0]] = 8'h5A;
      pushed++;
      repeat (2) begin
         @(negedge i_clk);
         n_tests++;
         if ({o_fifo_rd_en, o_valid, o_busy} !== 3'b000 ||
             o_data !== 8'h00 || o_word_count !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_out: rd=%b v=%b busy=%b d=%h cnt=%h, want 0",
                     o_fifo_rd_en, o_valid, o_busy, o_data, o_word_count);
         end
      end
      n_tests++;
      if (popped !== 0) begin
         n_fail++;
         $display("FAIL reset_noread: reads=%0d, want 0", popped);
      end
      @(posedge i_clk); #1;
      pushed = popped;
      i_rst  = 1'b0;
   endtask

   task automatic test_streaming();
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) push_word(8'hA1 + 8'(i));
      i_enable = 1'b1;
      i_ready  = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge i_clk);
         n_tests++;
         if (o_fifo_rd_en !== (c <= 3) || o_valid !== (c >= 2 && c <= 5) ||
             o_busy !== (c >= 1 && c <= 5)) begin
            n_fail++;
            $display("FAIL stream_timing c%0d: rd=%b v=%b busy=%b",
                     c, o_fifo_rd_en, o_valid, o_busy);
         end
         if (o_valid && i_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL stream_extra: got %h, none expected", o_data);
            end else begin
               e = exp_q.pop_front();
               if (o_data !== e) begin
                  n_fail++;
                  $display("FAIL stream_data: got %h, want %h", o_data, e);
               end
            end
         end
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (o_word_count !== 4'd4 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stream_count: cnt=%0d left=%0d, want 4 and 0",
                  o_word_count, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] e;
      int rds;
      do_reset();
      for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
      i_enable = 1'b1;
      rds = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge i_clk);
         rds += int'(o_fifo_rd_en);
         if (o_valid) begin
            n_tests++;
            if (o_data !== 8'h10) begin
               n_fail++;
               $display("FAIL bp_hold c%0d: got %h, want 10", c, o_data);
            end
         end
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (rds != 3) begin
         n_fail++;
         $display("FAIL bp_reads: got %0d, want 3", rds);
      end
      i_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clk);
         if (c < 2) begin
            n_tests++;
            if (o_fifo_rd_en !== (c == 1)) begin
               n_fail++;
               $display("FAIL bp_resume c%0d: rd=%b, want %b",
                        c, o_fifo_rd_en, c == 1);
            end
         end
         if (o_valid && i_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL bp_extra: got %h, none expected", o_data);
            end else begin
               e = exp_q.pop_front();
               if (o_data !== e) begin
                  n_fail++;
                  $display("FAIL bp_data: got %h, want %h", o_data, e);
               end
            end
         end
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (o_word_count !== 4'd5 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_count: cnt=%0d left=%0d, want 5 and 0",
                  o_word_count, exp_q.size());
      end
   endtask

   task automatic test_enable_drop();
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 8; i++) push_word(8'h20 + 8'(i));
      i_ready = 1'b1;
      for (int c = 0; c < 25; c++) begin
         i_enable = !(c >= 3 && c <= 6);
         @(negedge i_clk);
         if (!i_enable) begin
            n_tests++;
            if (o_fifo_rd_en !== 1'b0) begin
               n_fail++;
               $display("FAIL en_noread c%0d: rd=%b, want 0", c, o_fifo_rd_en);
            end
         end
         if (c == 6) begin
            n_tests++;
            if (o_valid !== 1'b0 || o_word_count !== 4'd3) begin
               n_fail++;
               $display("FAIL en_extra: v=%b cnt=%0d, want 0 and 3",
                        o_valid, o_word_count);
            end
         end
         if (o_valid && i_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL en_dup: got %h, none expected", o_data);
            end else begin
               e = exp_q.pop_front();
               if (o_data !== e) begin
                  n_fail++;
                  $display("FAIL en_data: got %h, want %h", o_data, e);
               end
            end
         end
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (o_word_count !== 4'd8 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL en_count: cnt=%0d left=%0d, want 8 and 0",
                  o_word_count, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 7; i++) push_word(8'h30 + 8'(i));
      i_enable = 1'b1;
      for (int c = 0; c < 8; c++) begin
         i_ready = (c <= 2) || (c >= 5);
         if (c == 4) i_rst = 1'b1;
         if (c == 5) begin
            i_rst  = 1'b0;
            pushed = popped;
            exp_q.delete();
         end
         @(negedge i_clk);
         if (c == 4) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_busy !== 1'b1 ||
                o_word_count !== 4'd1) begin
               n_fail++;
               $display("FAIL rm_pre: v=%b busy=%b cnt=%0d, want 1 1 1",
                        o_valid, o_busy, o_word_count);
            end
         end
         if (c >= 5) begin
            n_tests++;
            if (o_valid !== 1'b0 || o_busy !== 1'b0 ||
                o_word_count !== 4'd0 || o_data !== 8'h00) begin
               n_fail++;
               $display("FAIL rm_post c%0d: v=%b busy=%b cnt=%0d d=%h",
                        c, o_valid, o_busy, o_word_count, o_data);
            end
         end
         if (o_valid && i_ready && c < 4) begin
            n_tests++;
            e = exp_q.pop_front();
            if (o_data !== e) begin
               n_fail++;
               $display("FAIL rm_data: got %h, want %h", o_data, e);
            end
         end
         @(posedge i_clk); #1;
      end
   endtask

   task automatic test_wrap();
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 17; i++) push_word(8'h40 + 8'(i));
      i_enable = 1'b1;
      i_ready  = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge i_clk);
         if (o_valid && i_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL wrap_extra: got %h, none expected", o_data);
            end else begin
               e = exp_q.pop_front();
               if (o_data !== e) begin
                  n_fail++;
                  $display("FAIL wrap_data: got %h, want %h", o_data, e);
               end
            end
         end
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (o_word_count !== 4'd1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_count: cnt=%0d left=%0d, want 1 and 0",
                  o_word_count, exp_q.size());
      end
   endtask

   task automatic test_random();
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 24; i++) push_word(8'($urandom_range(0, 255)));
      for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
         i_ready  = 1'($urandom_range(0, 1));
         i_enable = ($urandom_range(0, 3) != 0);
         @(negedge i_clk);
         if (o_valid && i_ready) begin
            n_tests++;
            e = exp_q.pop_front();
            if (o_data !== e) begin
               n_fail++;
               $display("FAIL rand_data: got %h, want %h", o_data, e);
            end
         end
         @(posedge i_clk); #1;
      end
      @(negedge i_clk);
      n_tests++;
      if (exp_q.size() != 0 || o_word_count !== 4'd8) begin
         n_fail++;
         $display("FAIL rand_drain: left=%0d cnt=%0d, want 0 and 8",
                  exp_q.size(), o_word_count);
      end
      @(posedge i_clk); #1;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_enable_drop();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
